fifo_multichannel_drain_arbiter: RTL
====================================

# fifo_multichannel_drain_arbiter

Round-robin read scheduler sitting between the multichannel FIFO bank and the single outbound stream to the PS/DMA path. It grants one non-empty, enabled channel at a time, drains up to MAX_BURST words from it via the channel read ports, and emits them on one valid/ready stream tagged with channel ID and end-of-burst. A 2-entry output buffer absorbs the 1-cycle FIFO read latency and allows full throughput under backpressure.

## Interface
- RAM_WIDTH, 32, data word width (matches FIFO bank)
- FIFOS_CNT, 5, number of FIFO channels (≥2)
- MAX_BURST, 16, max words per grant (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_enable_channels  in  FIFOS_CNT  per-channel arbitration enable
- i_empty_channels  in  FIFOS_CNT  FIFO empty flags
- i_empty_next_channels  in  FIFOS_CNT  FIFO holds exactly one word
- o_rd_en_channels  out  FIFOS_CNT  FIFO read strobes (one-hot or zero)
- i_rd_valid_channels  in  FIFOS_CNT  FIFO read data valid
- i_rd_data_channels  in  FIFOS_CNT×RAM_WIDTH  FIFO read data
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts word
- o_data  out  RAM_WIDTH  output word
- o_channel_id  out  CH_W = max(1,$clog2(FIFOS_CNT))  source channel
- o_last  out  1  last word of current burst
- o_busy  out  1  state≠IDLE or words in flight/buffered
- o_protocol_err  out  1  sticky: unexpected rd_valid

## Operation
- eligible = i_enable_channels & ~i_empty_channels.
- States: IDLE, BURST.
- IDLE: if eligible≠0, grant first eligible index at or after ptr (wrapping mod FIFOS_CNT); register grant, clear issue_cnt, go BURST. Else stay.
- BURST: assert o_rd_en_channels[grant] when ~empty[grant] and space ≥1, where space = 2 − buf_count − inflight + (o_valid & i_ready).
- Each issued read records an in-flight tag {grant, last}; last = (issue_cnt == MAX_BURST−1) | empty_next[grant] | ~enable[grant].
- After issuing a read with last=1: ptr ← grant+1 (wrap at FIFOS_CNT), state ← IDLE.
- In BURST, if empty[grant] with no read issued that cycle (concurrent activity), no last is pending: next read (if any) is marked last when channel becomes non-empty; the burst never exceeds MAX_BURST.
- rd_valid on granted tag’s channel with inflight=1: push {data, tag} into output buffer. rd_valid elsewhere or with inflight=0: drop, set o_protocol_err.
- Output buffer: 2-entry FIFO, head drives o_data/o_channel_id/o_last; pop on o_valid & i_ready. o_data holds stable while o_valid & ~i_ready.
- Channel disabled mid-burst: next issued read carries last; already in-flight/buffered words still delivered.

## Timing
- Reset: state IDLE, ptr 0, grant 0, issue_cnt 0, inflight 0, buffer empty; all outputs 0.
- FIFO contract: rd_valid/data exactly 1 cycle after rd_en; empty flags reflect a read issued the previous cycle.
- Latency: eligible seen in IDLE at cycle t → rd_en at t+1 → rd_valid t+2 → o_valid t+3.
- Throughput: 1 word/cycle within a burst with i_ready=1; exactly one idle rd_en cycle between bursts.
- inflight ≤1; buf_count+inflight ≤2 at all times; no overflow, no word loss under any i_ready pattern.
- rst mid-burst: in-flight and buffered words discarded; returning rd_valid in the cycle after rst ignored without setting o_protocol_err.
- o_protocol_err cleared only by rst.

## Structure
- Package fifo_multichannel_pkg: CH_W localparam function, state enum (IDLE, BURST), in-flight tag struct {channel, last}.
- Sub-module rr_pointer_arbiter: combinational find-first-set from ptr with wrap, parameter FIFOS_CNT, outputs grant index and any-valid.
- Output buffer coded inline (2-entry register pair + count).

## Test plan
- Ch2 holds 3 words, others empty, i_ready=1 → rd_en[2] cycles 1–3, o_valid 3 words, o_channel_id=2, o_last on 3rd only.
- Ch0 and ch3 each hold 40 words, MAX_BURST=16 → bursts 0,3,0,3,0,3 of 16,16,16,16,8,8 words; o_last on each 16th/final word.
- All 5 channels non-empty, ptr=0 → grant order 0,1,2,3,4,0; one rd_en bubble between bursts.
- Ch1 holds 10 words, i_ready toggles 1,0,0,1 repeating → all 10 words delivered in order, no duplicates, o_data stable while stalled.
- Ch4 bursting, i_enable_channels[4] dropped after 5 words → next read marked last, ≤7 words total, then ch4 skipped.
- Spurious i_rd_valid_channels[1] while IDLE → o_protocol_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/fifo_multichannel_pkg.sv
// Shared types for the multichannel FIFO drain arbiter: channel-index width helper,
// scheduler state encoding and the tag that follows each outstanding FIFO read.
package fifo_multichannel_pkg;

    // Wide enough for any supported channel count; only the low CH_W bits are meaningful.
    localparam int unsigned TagChW = 8;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    typedef struct packed {
        logic [TagChW-1:0] channel;
        logic              last;
    } rd_tag_t;

endpackage

// File: rtl/rr_pointer_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping to index 0.
module rr_pointer_arbiter
    import fifo_multichannel_pkg::*;
#(
    parameter  int unsigned FIFOS_CNT = 5,
    localparam int unsigned CH_W      = ch_w(FIFOS_CNT)
) (
    input  logic [FIFOS_CNT-1:0] req_i,
    input  logic [CH_W-1:0]      ptr_i,
    output logic [CH_W-1:0]      grant_o,
    output logic                 valid_o
);

    logic            hi_found;
    logic [CH_W-1:0] hi_idx;
    logic [CH_W-1:0] lo_idx;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = FIFOS_CNT - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_idx = CH_W'(j);
                if (CH_W'(j) >= ptr_i) begin
                    hi_idx   = CH_W'(j);
                    hi_found = 1'b1;
                end
            end
        end
        grant_o = hi_found ? hi_idx : lo_idx;
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/fifo_multichannel_drain_arbiter.sv
// Round-robin burst drain of a FIFO bank onto one valid/ready stream, tagged with
// source channel and end-of-burst; a 2-entry buffer hides the 1-cycle FIFO read latency.
module fifo_multichannel_drain_arbiter
    import fifo_multichannel_pkg::*;
#(
    parameter  int unsigned RAM_WIDTH = 32,
    parameter  int unsigned FIFOS_CNT = 5,
    parameter  int unsigned MAX_BURST = 16,
    localparam int unsigned CH_W      = ch_w(FIFOS_CNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FIFOS_CNT-1:0]           i_enable_channels,
    input  logic [FIFOS_CNT-1:0]           i_empty_channels,
    input  logic [FIFOS_CNT-1:0]           i_empty_next_channels,
    output logic [FIFOS_CNT-1:0]           o_rd_en_channels,
    input  logic [FIFOS_CNT-1:0]           i_rd_valid_channels,
    input  logic [FIFOS_CNT*RAM_WIDTH-1:0] i_rd_data_channels,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [RAM_WIDTH-1:0]           o_data,
    output logic [CH_W-1:0]                o_channel_id,
    output logic                           o_last,
    output logic                           o_busy,
    output logic                           o_protocol_err
);

    localparam int unsigned CntW = ch_w(MAX_BURST);

    arb_state_e      state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drained_q, drained_d;
    logic            inflight_q;
    rd_tag_t         tag_q, tag_d;
    logic            err_q;
    logic            rst_dly_q;

    logic [RAM_WIDTH-1:0] buf_data_q [2];
    logic [CH_W-1:0]      buf_ch_q   [2];
    logic                 buf_last_q [2];
    logic [1:0]           buf_cnt_q;

    logic [FIFOS_CNT-1:0] eligible;
    logic [CH_W-1:0]      arb_grant;
    logic                 arb_valid;
    logic                 pop, push, spurious, space_ok;
    logic                 rd_issue, rd_last;
    logic [FIFOS_CNT-1:0] exp_mask;
    logic [RAM_WIDTH-1:0] rd_word;
    logic [CH_W-1:0]      rd_ch;

    assign eligible = i_enable_channels & ~i_empty_channels;

    rr_pointer_arbiter #(
        .FIFOS_CNT(FIFOS_CNT)
    ) u_rr (
        .req_i  (eligible),
        .ptr_i  (ptr_q),
        .grant_o(arb_grant),
        .valid_o(arb_valid)
    );

    assign pop = o_valid & i_ready;
    // buf_count + inflight never exceeds 2, so one free slot means "not full" or a pop this cycle.
    assign space_ok = ~(buf_cnt_q[1] | (buf_cnt_q[0] & inflight_q)) | pop;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        drained_d = drained_q;
        tag_d     = tag_q;
        rd_issue  = 1'b0;
        rd_last   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d   = arb_grant;
                    cnt_d     = '0;
                    drained_d = 1'b0;
                    state_d   = StBurst;
                end
            end
            StBurst: begin
                rd_last = (cnt_q == CntW'(MAX_BURST - 1)) | i_empty_next_channels[grant_q]
                        | ~i_enable_channels[grant_q] | drained_q;
                if (!i_empty_channels[grant_q] && space_ok) begin
                    rd_issue      = 1'b1;
                    tag_d.channel = TagChW'(grant_q);
                    tag_d.last    = rd_last;
                    cnt_d         = cnt_q + CntW'(1);
                    if (rd_last) begin
                        ptr_d   = (grant_q == CH_W'(FIFOS_CNT - 1)) ? '0 : grant_q + CH_W'(1);
                        state_d = StIdle;
                    end
                end else if (i_empty_channels[grant_q]) begin
                    // Channel drained under us without a last: close the burst on the next word.
                    drained_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_rd_en_channels = rd_issue ? (FIFOS_CNT'(1) << grant_q) : '0;

    // Only the channel of the outstanding tag may return data.
    always_comb begin
        exp_mask = '0;
        rd_word  = '0;
        rd_ch    = '0;
        for (int j = 0; j < FIFOS_CNT; j++) begin
            if (inflight_q && (tag_q.channel == TagChW'(j))) begin
                exp_mask[j] = 1'b1;
                rd_word     = i_rd_data_channels[j*RAM_WIDTH +: RAM_WIDTH];
                rd_ch       = CH_W'(j);
            end
        end
    end

    assign push     = |(i_rd_valid_channels & exp_mask);
    assign spurious = |(i_rd_valid_channels & ~exp_mask);

    always_ff @(posedge clk) begin
        rst_dly_q <= rst;
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            drained_q  <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            drained_q  <= drained_d;
            inflight_q <= rd_issue;
            tag_q      <= tag_d;
            // A read issued just before reset returns one cycle later; that is not an error.
            if (spurious && !rst_dly_q) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt_q <= '0;
            for (int k = 0; k < 2; k++) begin
                buf_data_q[k] <= '0;
                buf_ch_q[k]   <= '0;
                buf_last_q[k] <= 1'b0;
            end
        end else begin
            if (pop) begin
                buf_data_q[0] <= buf_data_q[1];
                buf_ch_q[0]   <= buf_ch_q[1];
                buf_last_q[0] <= buf_last_q[1];
            end
            if (push) begin
                if ((buf_cnt_q == 2'd0) || ((buf_cnt_q == 2'd1) && pop)) begin
                    buf_data_q[0] <= rd_word;
                    buf_ch_q[0]   <= rd_ch;
                    buf_last_q[0] <= tag_q.last;
                end else begin
                    buf_data_q[1] <= rd_word;
                    buf_ch_q[1]   <= rd_ch;
                    buf_last_q[1] <= tag_q.last;
                end
            end
            buf_cnt_q <= buf_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign o_valid        = |buf_cnt_q;
    assign o_data         = buf_data_q[0];
    assign o_channel_id   = buf_ch_q[0];
    assign o_last         = buf_last_q[0];
    assign o_busy         = (state_q != StIdle) | inflight_q | o_valid;
    assign o_protocol_err = err_q;

endmodule
